// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 host port: controller command encodings,
// bus widths and the host-port FSM state type.
package ddr3_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int FILL_W = 7;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_SCR = 3'd1,
        CMD_SCW = 3'd2,
        CMD_BLR = 3'd3,
        CMD_BLW = 3'd4,
        CMD_ATR = 3'd5,
        CMD_ATW = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Word address of a burst beat; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/ddr3_rtn_reg.sv
// One-entry return register between the controller return FIFO and the host
// read stream; issues single-cycle pops and captures data one cycle later.
module ddr3_rtn_reg
    import ddr3_pkg::*;
(
    input  logic              clk,
    input  logic              resetbar,
    input  logic              pop_en,
    input  logic [FILL_W-1:0] fillcount,
    input  logic [DATA_W-1:0] ctl_dout,
    input  logic [ADDR_W-1:0] ctl_raddr,
    output logic              ctl_read,
    output logic              capture,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready
);

    logic in_flight;
    logic drain;

    assign drain    = rd_valid & rd_ready;
    assign capture  = in_flight;
    // At most one pop outstanding, so the register is always free when its data lands.
    assign ctl_read = pop_en & (fillcount != '0) & ~in_flight & (~rd_valid | rd_ready);

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            in_flight <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_addr   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            in_flight <= ctl_read;
            if (capture) begin
                rd_valid <= 1'b1;
                rd_data  <= ctl_dout;
                rd_addr  <= ctl_raddr;
            end else if (drain) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ddr3_host_port.sv
// Host-side burst port: turns one host request into per-word controller
// commands and streams read returns back with address checking.
module ddr3_host_port
    import ddr3_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              resetbar,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              err,
    input  logic              ctl_ready,
    input  logic              ctl_notfull,
    input  logic [FILL_W-1:0] ctl_fillcount,
    input  logic [DATA_W-1:0] ctl_dout,
    input  logic [ADDR_W-1:0] ctl_raddr,
    output logic [2:0]        ctl_cmd,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_din,
    output logic              ctl_read
);

    localparam int CNT_W = LEN_W + 1;

    state_e            state, state_nxt;
    logic              wr_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  issue_cnt, ret_cnt, len_plus1;
    logic              accept, issue, last_issue, all_returned, pop_en, capture;

    assign len_plus1    = {1'b0, len_q} + CNT_W'(1);
    // Reset gating keeps req_ready low while resetbar is held, whatever ctl_ready does.
    assign req_ready    = resetbar & ctl_ready & (state == IDLE);
    assign accept       = req_valid & req_ready;
    assign wr_ready     = (state == ISSUE) & wr_q & ctl_notfull & ctl_ready;
    assign issue        = (state == ISSUE) & ctl_ready & ctl_notfull & (~wr_q | wr_valid);
    assign last_issue   = issue & (issue_cnt == {1'b0, len_q});
    assign all_returned = (ret_cnt == len_plus1) & ~rd_valid;
    assign pop_en       = ~wr_q & ctl_ready & ((state == ISSUE) | (state == DRAIN));
    assign busy         = (state != IDLE);

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = (wr_q || all_returned) ? IDLE : DRAIN;
            DRAIN:   if (all_returned) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            err       <= 1'b0;
            ctl_cmd   <= CMD_NOP;
            ctl_addr  <= '0;
            ctl_din   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q      <= req_write;
                base_q    <= req_addr;
                len_q     <= req_len;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (issue)   issue_cnt <= issue_cnt + CNT_W'(1);
                if (capture) ret_cnt   <= ret_cnt + CNT_W'(1);
            end
            ctl_cmd <= issue ? (wr_q ? CMD_SCW : CMD_SCR) : CMD_NOP;
            if (issue) begin
                ctl_addr <= addr_at(base_q, ADDR_W'(issue_cnt));
                ctl_din  <= wr_data;
            end
            // Returns arrive in issue order, so the Nth capture must carry base + N.
            if (capture && (ctl_raddr != addr_at(base_q, ADDR_W'(ret_cnt)))) err <= 1'b1;
        end
    end

    ddr3_rtn_reg u_rtn_reg (
        .clk       (clk),
        .resetbar  (resetbar),
        .pop_en    (pop_en),
        .fillcount (ctl_fillcount),
        .ctl_dout  (ctl_dout),
        .ctl_raddr (ctl_raddr),
        .ctl_read  (ctl_read),
        .capture   (capture),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready)
    );

endmodule

// File: tb/tb_ddr3_host_port.sv
// Bench for ddr3_host_port: a behavioural controller with a return FIFO plus
// expected command/return queues built from base + i address arithmetic.
module tb_ddr3_host_port;
    import ddr3_pkg::*;

    localparam int LEN_W = 4;

    logic              clk = 1'b0;
    logic              resetbar = 1'b0;
    logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LEN_W-1:0]  req_len = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0, wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid, rd_ready = 1'b1;
    logic              busy, err;
    logic              ctl_ready = 1'b0, ctl_notfull = 1'b1;
    logic [FILL_W-1:0] ctl_fillcount = '0;
    logic [DATA_W-1:0] ctl_dout = '0;
    logic [ADDR_W-1:0] ctl_raddr = '0;
    logic [2:0]        ctl_cmd;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_din;
    logic              ctl_read;

    always #5 clk = ~clk;

    ddr3_host_port #(.LEN_W(LEN_W)) dut (
        .clk(clk), .resetbar(resetbar),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .err(err),
        .ctl_ready(ctl_ready), .ctl_notfull(ctl_notfull), .ctl_fillcount(ctl_fillcount),
        .ctl_dout(ctl_dout), .ctl_raddr(ctl_raddr),
        .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_read(ctl_read)
    );

    typedef struct {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } cmd_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ret_t;

    int   checks = 0;
    int   errors = 0;
    cmd_t exp_cmd[$];
    ret_t exp_ret[$];
    logic [DATA_W-1:0] wdata[$];
    logic [31:0] corrupt_addr = '1;

    // Per-cycle samples taken at the falling edge by tick().
    logic              s_accept, s_wr_hs, s_busy, s_req_ready, s_read;
    logic [2:0]        s_cmd;
    logic              rv_hold = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] hold_addr;

    function automatic logic [DATA_W-1:0] ret_data(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {7'b0, a[24:16]};
    endfunction

    function automatic logic [90:0] reset_vec();
        return {req_ready, wr_ready, rd_valid, busy, err, ctl_read,
                ctl_cmd, ctl_addr, ctl_din, rd_data, rd_addr};
    endfunction

    // Controller model: samples the DUT at the falling edge, updates after the rising edge.
    ret_t              fifo[$];
    logic [2:0]        m_cmd = CMD_NOP;
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_read = 1'b0;

    always @(negedge clk) begin
        m_cmd  = ctl_cmd;
        m_addr = ctl_addr;
        m_read = ctl_read;
    end

    always @(posedge clk) begin
        ret_t r;
        #1;
        if (!resetbar) begin
            fifo.delete();
        end else begin
            if (m_read && fifo.size() != 0) begin
                r         = fifo.pop_front();
                ctl_dout  = r.data;
                ctl_raddr = r.addr;
            end
            if (m_cmd == CMD_SCR) begin
                r.addr = ({7'b0, m_addr} == corrupt_addr) ? (m_addr ^ 25'd1) : m_addr;
                r.data = ret_data(m_addr);
                fifo.push_back(r);
            end
        end
        ctl_fillcount = ($urandom_range(0, 3) == 0) ? '0 : FILL_W'(fifo.size());
    end

    task automatic tick();
        cmd_t c;
        ret_t r;
        @(negedge clk);
        s_accept    = req_valid & req_ready;
        s_wr_hs     = wr_valid & wr_ready;
        s_busy      = busy;
        s_req_ready = req_ready;
        s_cmd       = ctl_cmd;
        s_read      = ctl_read;
        if (ctl_cmd !== CMD_NOP) begin
            checks++;
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL cmd_extra got cmd=%0d addr=%h, expected no command", ctl_cmd, ctl_addr);
            end else begin
                c = exp_cmd.pop_front();
                if (ctl_cmd !== c.cmd || ctl_addr !== c.addr ||
                    (c.cmd == CMD_SCW && ctl_din !== c.din)) begin
                    errors++;
                    $display("FAIL cmd_stream got cmd=%0d addr=%h din=%h, expected cmd=%0d addr=%h din=%h",
                             ctl_cmd, ctl_addr, ctl_din, c.cmd, c.addr, c.din);
                end
            end
        end
        if (rd_valid === 1'b1) begin
            if (rv_hold) begin
                checks++;
                if (rd_data !== hold_data || rd_addr !== hold_addr) begin
                    errors++;
                    $display("FAIL rd_stable got %h@%h, expected %h@%h", rd_data, rd_addr, hold_data, hold_addr);
                end
            end
            if (rd_ready !== 1'b1) begin
                checks++;
                if (ctl_read !== 1'b0) begin
                    errors++;
                    $display("FAIL pop_while_stuck got ctl_read=%b, expected 0", ctl_read);
                end
            end else begin
                checks++;
                if (exp_ret.size() == 0) begin
                    errors++;
                    $display("FAIL ret_extra got %h@%h, expected no return", rd_data, rd_addr);
                end else begin
                    r = exp_ret.pop_front();
                    if (rd_data !== r.data || rd_addr !== r.addr) begin
                        errors++;
                        $display("FAIL ret_stream got %h@%h, expected %h@%h", rd_data, rd_addr, r.data, r.addr);
                    end
                end
            end
        end
        rv_hold   = (rd_valid === 1'b1) && (rd_ready !== 1'b1);
        hold_data = rd_data;
        hold_addr = rd_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input bit wr, input logic [ADDR_W-1:0] addr, input int len);
        cmd_t c;
        ret_t r;
        logic [ADDR_W-1:0] a;
        wdata.delete();
        for (int i = 0; i <= len; i++) begin
            a = addr + ADDR_W'(i);
            wdata.push_back(DATA_W'($urandom));
            c.cmd  = wr ? CMD_SCW : CMD_SCR;
            c.addr = a;
            c.din  = wdata[i];
            exp_cmd.push_back(c);
            if (!wr) begin
                r.addr = ({7'b0, a} == corrupt_addr) ? (a ^ 25'd1) : a;
                r.data = ret_data(a);
                exp_ret.push_back(r);
            end
        end
        req_write = wr;
        req_addr  = addr;
        req_len   = LEN_W'(len);
    endtask

    // Drives the data/flow-control side until the request completes; the optional
    // windows force notfull low (5 cycles), rd_ready low (10) or ctl_ready low (6).
    task automatic drive_until_done(input bit wr, input int len, input bit calm,
                                    input int nf_at, input int rs_at, input int dr_at);
        int idx = 0;
        int cyc = 0;
        int ncmd = 0;
        int first_cyc = -1;
        while ((busy || exp_cmd.size() != 0 || exp_ret.size() != 0) && cyc < 2000) begin
            wr_valid    = wr && idx <= len && (calm || $urandom_range(0, 3) != 0);
            wr_data     = (idx <= len) ? wdata[idx] : DATA_W'($urandom);
            ctl_notfull = (nf_at >= 0 && cyc >= nf_at && cyc < nf_at + 5) ? 1'b0 :
                          (calm || $urandom_range(0, 4) != 0);
            rd_ready    = (rs_at >= 0 && cyc >= rs_at && cyc < rs_at + 10) ? 1'b0 :
                          (calm || $urandom_range(0, 2) != 0);
            ctl_ready   = !(dr_at >= 0 && cyc >= dr_at && cyc < dr_at + 6);
            tick();
            if (s_wr_hs) idx++;
            if (s_cmd !== CMD_NOP) begin
                ncmd++;
                if (first_cyc < 0) first_cyc = cyc;
                if (calm && ncmd == len + 1) begin
                    checks++;
                    if (cyc - first_cyc != len || (wr && s_busy !== 1'b0)) begin
                        errors++;
                        $display("FAIL calm_burst got span=%0d busy=%b, expected span=%0d busy=%b",
                                 cyc - first_cyc, s_busy, len, !wr);
                    end
                end
            end
            if (dr_at >= 0 && cyc > dr_at && cyc < dr_at + 6) begin
                checks++;
                if (s_cmd !== CMD_NOP || s_read !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_low_quiet got cmd=%0d read=%b, expected 0/0", s_cmd, s_read);
                end
            end
            cyc++;
        end
        wr_valid    = 1'b0;
        ctl_notfull = 1'b1;
        rd_ready    = 1'b1;
        ctl_ready   = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || exp_cmd.size() != 0 || exp_ret.size() != 0) begin
            errors++;
            $display("FAIL req_done got busy=%b cmds_left=%0d rets_left=%0d, expected 0/0/0",
                     busy, exp_cmd.size(), exp_ret.size());
        end
    endtask

    task automatic run_req(input bit wr, input logic [ADDR_W-1:0] addr, input int len,
                           input bit calm, input int nf_at, input int rs_at, input int dr_at);
        int cyc = 0;
        push_expect(wr, addr, len);
        req_valid = 1'b1;
        do begin
            tick();
            cyc++;
        end while (!s_accept && cyc < 50);
        req_valid = 1'b0;
        checks++;
        if (!s_accept) begin
            errors++;
            $display("FAIL accept got no handshake in %0d cycles, expected acceptance", cyc);
        end
        drive_until_done(wr, len, calm, nf_at, rs_at, dr_at);
    endtask

    task automatic test_reset();
        resetbar  = 1'b0;
        ctl_ready = 1'b1;
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (reset_vec() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h, expected 0", reset_vec());
        end
        req_valid = 1'b0;
        resetbar  = 1'b1;
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got busy=%b req_ready=%b, expected 0/1", s_busy, s_req_ready);
        end
    endtask

    task automatic test_init_gate();
        ctl_ready = 1'b0;
        push_expect(1'b0, 25'h0000040, 0);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_req_ready !== 1'b0 || s_cmd !== CMD_NOP || s_accept !== 1'b0) begin
                errors++;
                $display("FAIL init_gate got req_ready=%b cmd=%0d, expected 0/NOP", s_req_ready, s_cmd);
            end
        end
        ctl_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (s_accept !== 1'b1) begin
            errors++;
            $display("FAIL init_accept got accept=%b, expected 1", s_accept);
        end
        drive_until_done(1'b0, 0, 1'b1, -1, -1, -1);
    endtask

    task automatic test_write_burst();
        run_req(1'b1, 25'h0000010, 3, 1'b1, -1, -1, -1);
        run_req(1'b1, 25'h0ABCDE0, 0, 1'b1, -1, -1, -1);
    endtask

    task automatic test_read_wrap();
        run_req(1'b0, 25'h1FFFFFE, 3, 1'b1, -1, -1, -1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL read_wrap_err got err=%b, expected 0", err);
        end
    endtask

    task automatic test_stalls();
        run_req(1'b1, 25'h0001200, 7, 1'b0, 2, -1, -1);
        run_req(1'b0, 25'h0003400, 15, 1'b0, -1, 3, -1);
        run_req(1'b0, 25'h0005600, 9, 1'b0, -1, -1, 3);
        run_req(1'b1, 25'h0007800, 5, 1'b0, -1, -1, 2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_req(1'($urandom), ADDR_W'($urandom), int'($urandom_range(0, 15)), 1'b0, -1, -1, -1);
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL random_err got err=%b, expected 0 (req %0d)", err, n);
            end
        end
    endtask

    task automatic test_err_sticky();
        corrupt_addr = 32'h0000_9002;
        run_req(1'b0, 25'h0009000, 3, 1'b0, -1, -1, -1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got err=%b, expected 1", err);
        end
        corrupt_addr = '1;
        run_req(1'b0, 25'h000A000, 2, 1'b0, -1, -1, -1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got err=%b, expected 1", err);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        push_expect(1'b0, 25'h000C000, 15);
        req_valid = 1'b1;
        do begin
            tick();
            cyc++;
        end while (!s_accept && cyc < 50);
        req_valid = 1'b0;
        repeat (6) tick();
        #2;
        resetbar = 1'b0;
        #1;
        checks++;
        if (reset_vec() !== '0) begin
            errors++;
            $display("FAIL reset_async got %h, expected 0", reset_vec());
        end
        exp_cmd.delete();
        exp_ret.delete();
        rv_hold = 1'b0;
        @(posedge clk);
        #1;
        resetbar = 1'b1;
        run_req(1'b0, 25'h000D000, 4, 1'b0, -1, -1, -1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_err got err=%b, expected 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_write_burst();
        test_read_wrap();
        test_stalls();
        test_random();
        test_err_sticky();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_host_port.md
DDR3_HOST_PORT -- requirements
Module: ddr3_host_port

Interface
REQ-001 Parameter LEN_W, default 4: request length field width; max burst = 2^LEN_W words.
REQ-002 Port clk  in  1: single clock; all state SHALL change on its rising edge only.
REQ-003 Port resetbar  in  1: asynchronous, active-low reset.
REQ-004 Port req_valid / req_ready  in / out  1 / 1: host request handshake; accepted on the cycle both are high.
REQ-005 Port req_write  in  1: 1 = write, 0 = read.
REQ-006 Port req_addr  in  25: base word address.
REQ-007 Port req_len  in  LEN_W: word count minus 1.
REQ-008 Port wr_data / wr_valid / wr_ready  in / in / out  16 / 1 / 1: write-data stream.
REQ-009 Port rd_data / rd_addr / rd_valid / rd_ready  out / out / out / in  16 / 25 / 1 / 1: read-return stream.
REQ-010 Port busy / err  out  1 / 1: request in progress; sticky return-address mismatch.
REQ-011 Ports ctl_ready, ctl_notfull  in  1 each: controller initialised; command FIFO has space.
REQ-012 Ports ctl_fillcount  in  7; ctl_dout  in  16; ctl_raddr  in  25: controller return FIFO status and data.
REQ-013 Ports ctl_cmd  out  3; ctl_addr  out  25; ctl_din  out  16; ctl_read  out  1: controller command push and return pop.

Function
REQ-014 FSM states: IDLE, ISSUE, DRAIN.
REQ-015 IDLE: req_ready = ctl_ready; on accept, latch write, addr, len; clear issue_cnt and ret_cnt; go to ISSUE.
REQ-016 ISSUE: a command issues in a cycle iff ctl_notfull=1, and for writes also wr_valid=1; wr_ready = (state==ISSUE) & req_write & ctl_notfull.
REQ-017 Issued command: ctl_cmd = CMD_SCW (write) or CMD_SCR (read); ctl_addr = base + issue_cnt mod 2^25 (wrap, no carry out); ctl_din = wr_data.
REQ-018 Cycles without an issued command SHALL drive ctl_cmd = CMD_NOP; ctl_addr and ctl_din hold their previous values.
REQ-019 After the last command (issue_cnt == len): write returns to IDLE; read goes to DRAIN unless all returns are already counted, in which case it returns to IDLE.
REQ-020 Return pop: ctl_read pulses for one cycle when ctl_fillcount != 0, no pop is in flight, and the return register is empty or being drained that cycle. Applies in ISSUE and DRAIN.
REQ-021 Pop latency: ctl_dout/ctl_raddr are captured the cycle after ctl_read into rd_data/rd_addr, with rd_valid set.
REQ-022 rd_valid holds with stable data until rd_ready; simultaneous capture and drain SHALL be lossless.
REQ-023 Each capture increments ret_cnt and compares ctl_raddr with base + ret_cnt; a mismatch sets err until reset.
REQ-024 DRAIN returns to IDLE when ret_cnt == len+1 and rd_valid is cleared.
REQ-025 busy = (state != IDLE).
REQ-026 ctl_ready falling mid-request: stop issuing and popping, hold counters; resume when it rises.
REQ-027 req_valid while busy: ignored (req_ready=0); no queuing.
REQ-028 len = 0: exactly one command; len = max: 2^LEN_W commands, counters sized LEN_W+1.

Reset
REQ-029 resetbar low, asynchronous: state=IDLE, counters=0; req_ready, wr_ready, rd_valid, busy, err, ctl_read = 0; ctl_cmd = CMD_NOP; ctl_addr, ctl_din, rd_data, rd_addr = 0.
REQ-030 Reset mid-request aborts it without completing; in-flight pops are discarded.
REQ-031 Deassertion is synchronised externally; first request is accepted no earlier than the first edge after release with ctl_ready=1.

Structure
REQ-032 Shared package ddr3_pkg SHALL hold the 3-bit command encodings (CMD_NOP=0, CMD_SCR=1, CMD_SCW=2, CMD_BLR=3, CMD_BLW=4, CMD_ATR=5, CMD_ATW=6), ADDR_W=25, DATA_W=16, FILL_W=7, and the FSM state type.
REQ-033 One sub-module, ddr3_rtn_reg: one-entry valid/ready return register (data+addr) with pop-in-flight tracking.

Verification
REQ-034 Before init completes (ctl_ready=0), req_valid=1 -> req_ready=0 and ctl_cmd=NOP; after ctl_ready=1, request accepted next edge.
REQ-035 Write addr=0x0000010, len=3, data 0xA0..0xA3, notfull=1 -> four consecutive CMD_SCW to 0x10..0x13 with matching din; busy low after the 4th.
REQ-036 Read addr=0x1FFFFFE, len=3 -> CMD_SCR to 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001; four returns in order; err=0.
REQ-037 notfull deasserted 5 cycles mid-write, plus rd_ready held low 10 cycles during a 16-word read -> no lost or duplicated commands or returns; ctl_read never pops while rd_valid is stuck.
REQ-038 Return with wrong raddr -> err=1 and sticky; resetbar pulsed mid-read -> all outputs at REQ-029 values asynchronously, next request proceeds normally.
